edge_gen: RTL

- Inverse of the team's edge detector: rebuilds a level waveform from single-cycle edge-request pulses (rise, fall, toggle).
- Enforces a minimum hold time on the output level.
- Keeps a one-deep pending target and reports requests that cancel each other before taking effect.
- Sits in front of pads or handshake lines driven by event-based control logic.

---
 rtl/edge_gen_pkg.sv | 16 +
 rtl/edge_gen_hold_timer.sv | 20 ++
 rtl/edge_gen.sv | 79 +++++++
 3 files changed

// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared state type, timer width and request decode for edge_gen.
package edge_gen_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, PEND} edge_gen_state_t;

   function automatic int hold_w(input int min_hold);
      return (min_hold < 1) ? 1 : $clog2(min_hold + 1);
   endfunction

   // Toggle wins over rise/fall; rise together with fall acts as a toggle.
   function automatic logic next_target(input logic rise, input logic fall, input logic toggle,
                                        input logic target);
      return (toggle || (rise && fall)) ? ~target : rise ? 1'b1 : fall ? 1'b0 : target;
   endfunction

endpackage

// File: rtl/edge_gen_hold_timer.sv
// edge_gen_hold_timer: loadable down-counter that stops at zero.
module edge_gen_hold_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o,
   output logic         last_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : expired_o ? cnt_q : cnt_q - 1'b1;
   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign expired_o = cnt_q == '0;
   assign last_o    = cnt_q == W'(1);
endmodule

// File: rtl/edge_gen.sv
// edge_gen: rebuilds a level from rise/fall/toggle pulses with a minimum hold time.
// Define EDGE_GEN_CNT_EN to add the edge_cnt output counting changes of out.
module edge_gen
   import edge_gen_pkg::*;
#(
   parameter int MIN_HOLD = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             rise_req,
   input  logic             fall_req,
   input  logic             toggle_req,
   output logic             out,
   output logic             busy,
   output logic             drop
`ifdef EDGE_GEN_CNT_EN
   ,
   output logic [CNT_W-1:0] edge_cnt
`endif
);
   localparam int HW = hold_w(MIN_HOLD);
   edge_gen_state_t state_q, state_d;
   logic out_q, out_d, target_q, target_d, drop_q, drop_d, busy_q;
   logic nt, load, apply, expired, last;
   assign nt = next_target(rise_req, fall_req, toggle_req, target_q);
   edge_gen_hold_timer #(.W(HW)) u_timer (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (load),
      .load_val_i (HW'(MIN_HOLD - 1)),
      .expired_o  (expired),
      .last_o     (last)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         out_q    <= 1'b0;
         target_q <= 1'b0;
         drop_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         target_q <= target_d;
         drop_q   <= drop_d;
         busy_q   <= state_d != IDLE;
      end
   end
   // PEND lingers at count zero for one cycle so out is held the full MIN_HOLD cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (nt != out_q && MIN_HOLD > 1) ? HOLD : IDLE;
         HOLD:    state_d = (nt != out_q) ? PEND : last ? IDLE : HOLD;
         PEND:    state_d = expired ? ((nt != target_q) ? PEND : HOLD)
                                    : (nt == out_q) ? (last ? IDLE : HOLD) : PEND;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      apply    = state_q == PEND && expired;
      load     = (state_q == IDLE && nt != out_q) || apply;
      out_d    = (state_q == IDLE) ? nt : apply ? target_q : out_q;
      target_d = nt;
      drop_d   = state_q == PEND && !expired && nt == out_q;
   end
   assign out  = out_q;
   assign busy = busy_q;
   assign drop = drop_q;
`ifdef EDGE_GEN_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_q + CNT_W'(out_d != out_q);
   end
   assign edge_cnt = cnt_q;
`endif
endmodule
